rng_ctrl: RTL
=============

# rng_ctrl

Sequencing and sharing controller for the 20-bit LFSR digit generator (`rng`).
- Owns the generator's `rst`/`seed` pins.
- Captures an entropy seed from a free-running counter on a user reseed pulse.
- Holds the generator idle until it has settled.
- Hands out 5-digit BCD numbers to `NUM_REQ` requesters via round-robin grant.
- Enforces a minimum spacing between grants so no two consumers receive correlated (one-shift-apart) values.

## Interface
- `NUM_REQ`, default 4, number of requesters (2..8).
- `SETTLE_CYCLES`, default 2, cycles after generator reset release before the first grant.
- `MIN_GAP`, default 20, minimum cycles from one grant to the next (full LFSR refresh), ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `reseed`  in  1  synchronous pulse; request a new seed.
- `req`  in  `NUM_REQ`  level request per requester, held until granted.
- `gnt`  out  `NUM_REQ`  one-hot, one-cycle grant pulse.
- `num`  out  20  granted value, five BCD digits, `[19:16]` most significant.
- `busy`  out  1  high when no grant can issue this cycle.
- `rng_rst`  out  1  drives generator `rst`.
- `rng_seed`  out  20  drives generator `seed`.
- `rng_num`  in  20  generator `random_num`.

## Operation
- Free-running 20-bit `seed_cnt` increments every cycle from 0 after reset and wraps `0xFFFFF`→0.
- States: HOLD, LOAD, SETTLE, SERVE.
- HOLD (reset state):
  - `rng_rst`=1; `rng_seed` holds its current value, which is `20'h00001` out of reset.
  - `reseed` captures `seed_cnt` into `rng_seed`, substituting `20'h00001` if `seed_cnt`=0 (LFSR lockup guard), then → LOAD.
- LOAD: `rng_rst`=1 for exactly one cycle with the new seed stable, then → SETTLE.
- SETTLE:
  - `rng_rst`=0.
  - Counter runs `SETTLE_CYCLES` cycles, then → SERVE with `gap_cnt`=0.
- SERVE:
  - Grant issues when `gap_cnt`=0, `req` is nonzero and `reseed`=0.
  - The round-robin arbiter picks the lowest index ≥ `ptr` (wrapping).
  - `gnt`=onehot(i) and `num`←`rng_num` are registered, so they appear on the cycle after the request is sampled.
  - Then `ptr`←(i+1) mod `NUM_REQ` and `gap_cnt`←`MIN_GAP`-1.
  - `gap_cnt` decrements each cycle to 0.
- Reseed in SERVE takes priority over any grant that cycle: capture seed as in HOLD → LOAD. `gap_cnt` and `ptr` are kept; pending requests wait.
- `reseed` in LOAD or SETTLE is ignored.
- `busy` = (state≠SERVE) | (`gap_cnt`≠0).
- `num` holds its value between grants and is never cleared except by reset.

## Timing
- Reset values:
  - `gnt`=0, `num`=0, `busy`=1, `rng_rst`=1, `rng_seed`=`20'h00001`.
  - `ptr`=0, `gap_cnt`=0, `seed_cnt`=0.
- Reseed sampled at edge t:
  - `rng_rst` stays high through t+1.
  - Low from t+2.
  - SERVE entered at t+2+`SETTLE_CYCLES`.
- Grant latency: `req` sampled at edge t gives `gnt`/`num` valid in cycle t+1 (one-cycle pulse).
- Consecutive grants are at least `MIN_GAP` cycles apart. A requester that holds `req` is served within `NUM_REQ`·`MIN_GAP` cycles of SERVE.
- Requester dropping `req` before grant: no grant and no pointer change.
- Reset mid-operation clears everything immediately (asynchronous), including any `gnt` pulse in flight. The generator is reset via `rng_rst`=1.

## Structure
- `rng_pkg` holds:
  - State enum.
  - `LFSR_W`=20, `DIGITS`=5.
  - `SEED_GUARD`=`20'h00001`.
- Sub-module `rr_arbiter`: parameterised `NUM_REQ` one-hot round-robin picker (`req`, `ptr` → `onehot`, `idx`), combinational. The FSM, counters and registers stay in `rng_ctrl`.
- `rng_ctrl` instantiates nothing else. `rng` is instantiated alongside it at the level above.

## Test plan
- Reset → `rng_rst`=1, `rng_seed`=`0x00001`, `busy`=1, `gnt`=0. `req`=`4'b1111` held 50 cycles gives no grant.
- `reseed` when `seed_cnt`=`0x00123` → `rng_seed`=`0x00123`, `rng_rst` high 2 cycles then low, first grant 2 cycles after release, and `num` equals the `rng_num` sampled on the preceding cycle (every digit ≤9).
- Force `seed_cnt` wrap to 0 at reseed → `rng_seed`=`0x00001`.
- `req`=`4'b1111` constant, `MIN_GAP`=20 → grants to 0,1,2,3,0 spaced exactly 20 cycles. `busy` high for 19 cycles after each grant.
- `reseed` and an eligible `req` in the same SERVE cycle → no `gnt`, enter LOAD. After settle, grant goes to the preserved `ptr` index.
- Assert `rst` during SETTLE and during a `gnt` cycle → all outputs return to reset values within the same cycle, and `ptr`=0 afterward.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared definitions for the LFSR digit generator controller.
// Contents: controller state enum, generator width / digit count, and the seed
// that replaces an all-zero capture.
package rng_pkg;

  localparam int unsigned LFSR_W = 20;
  localparam int unsigned DIGITS = 5;

  // An all-zero LFSR never leaves zero, so a zero capture is replaced by this.
  localparam logic [LFSR_W-1:0] SEED_GUARD = 20'h00001;

  typedef enum logic [1:0] {
    StHold,
    StLoad,
    StSettle,
    StServe
  } rng_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req     in   NUM_REQ         request vector
//   ptr     in   clog2(NUM_REQ)  highest-priority index this round
//   onehot  out  NUM_REQ         one-hot winner, zero when req is zero
//   idx     out  clog2(NUM_REQ)  binary winner index, zero when req is zero
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin : pick
    logic            found;
    logic [IdxW-1:0] cand;
    found  = 1'b0;
    cand   = '0;
    onehot = '0;
    idx    = '0;
    // Walk from ptr upward, wrapping, and keep the first requester seen.
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IdxW'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rng_ctrl.sv
// Sequencing and sharing controller for the 20-bit LFSR digit generator.
// Owns the generator reset/seed, captures a seed from a free-running counter on
// reseed, waits for the generator to settle, then hands out registered 5-digit
// BCD values to NUM_REQ requesters round-robin, at most one grant per MIN_GAP
// cycles so no two consumers see values one shift apart.
// Ports:
//   clk       in   1        clock
//   rst       in   1        asynchronous active-high reset
//   reseed    in   1        pulse: capture a new seed and restart the generator
//   req       in   NUM_REQ  level requests, held until granted
//   gnt       out  NUM_REQ  one-hot one-cycle grant
//   num       out  20       value handed out with the grant (BCD, [19:16] MSD)
//   busy      out  1        no grant can issue this cycle
//   rng_rst   out  1        generator reset
//   rng_seed  out  20       generator seed
//   rng_num   in   20       generator output
module rng_ctrl
  import rng_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MIN_GAP       = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reseed,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [4*DIGITS-1:0]   num,
  output logic                  busy,
  output logic                  rng_rst,
  output logic [LFSR_W-1:0]     rng_seed,
  input  logic [LFSR_W-1:0]     rng_num
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned GapW = $clog2(MIN_GAP + 1);
  localparam int unsigned SetW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  rng_state_e          state_q, state_d;
  logic [LFSR_W-1:0]   seed_cnt_q;
  logic [LFSR_W-1:0]   seed_q, seed_d;
  logic                rng_rst_q, rng_rst_d;
  logic [SetW-1:0]     settle_q, settle_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [4*DIGITS-1:0] num_q, num_d;

  logic [NUM_REQ-1:0]  arb_onehot;
  logic [IdxW-1:0]     arb_idx;
  logic [LFSR_W-1:0]   seed_capture;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  assign seed_capture = (seed_cnt_q == '0) ? SEED_GUARD : seed_cnt_q;

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    settle_d = settle_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    num_d    = num_q;
    gap_d    = (gap_q != '0) ? gap_q - GapW'(1) : gap_q;

    unique case (state_q)
      StHold: begin
        if (reseed) begin
          seed_d  = seed_capture;
          state_d = StLoad;
        end
      end
      StLoad: begin
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SetW'(SETTLE_CYCLES)) begin
          gap_d   = '0;
          state_d = StServe;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      StServe: begin
        // Reseed wins over a grant; ptr and pending requests carry over.
        if (reseed) begin
          seed_d  = seed_capture;
          state_d = StLoad;
        end else if ((gap_q == '0) && (req != '0)) begin
          gnt_d = arb_onehot;
          num_d = rng_num;
          ptr_d = (arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
          gap_d = GapW'(MIN_GAP - 1);
        end
      end
      default: state_d = StHold;
    endcase

    // Registered so the generator reset spans the LOAD cycle and the one after
    // it, with the new seed already stable on both.
    rng_rst_d = (state_d == StHold) || (state_d == StLoad) || (state_q == StLoad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHold;
      seed_cnt_q <= '0;
      seed_q     <= SEED_GUARD;
      rng_rst_q  <= 1'b1;
      settle_q   <= '0;
      gap_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      seed_cnt_q <= seed_cnt_q + LFSR_W'(1);
      seed_q     <= seed_d;
      rng_rst_q  <= rng_rst_d;
      settle_q   <= settle_d;
      gap_q      <= gap_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      num_q      <= num_d;
    end
  end

  assign gnt      = gnt_q;
  assign num      = num_q;
  assign busy     = (state_q != StServe) || (gap_q != '0);
  assign rng_rst  = rng_rst_q;
  assign rng_seed = seed_q;

endmodule
